uart_rxd: RTL and testbench

Asynchronous serial receiver for 8-bit UART frames: 1 start bit, 8 data bits LSB first, optional parity bit, and 1 stop bit. The default rate is 115200 baud from a 50 MHz system clock. It pairs with the team's UART transmitter and uses the same parity encoding, so loopback works with no glue logic. Received bytes are presented with a one-cycle `rxd_done` strobe and per-frame error flags.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rxd.sv | 125 ++++++++++++
 tb/tb_uart_rxd.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM states and default rates.
package uart_pkg;

  localparam int SYS_FREQ_DEF = 50_000_000;
  localparam int BAUD_DEF     = 115200;

  localparam logic [1:0] P_EVEN = 2'b00;
  localparam logic [1:0] P_ODD  = 2'b01;
  localparam logic [1:0] P_NONE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Both 2'b10 and 2'b11 mean "no parity bit on the line".
  function automatic logic parity_enabled(input logic [1:0] mode);
    return ~mode[1];
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus a third flop for falling-edge detection.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxd_s,
  output logic rxd_fall
);

  logic [2:0] sync_q;

  // Flops reset low so that a line already low at reset release is not mistaken for a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], rxd};
    end
  end

  assign rxd_s    = sync_q[1];
  assign rxd_fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart_rxd.sv
// UART receiver: 8 data bits LSB first, optional even/odd parity, one stop bit, with per-frame error flags.
module uart_rxd
  import uart_pkg::*;
#(
  parameter int SYS_FREQ = SYS_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic [1:0] parity,
  output logic [7:0] rxd_data,
  output logic       rxd_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rxd_busy
);

  localparam int BAUD_DR = SYS_FREQ / BAUD;
  localparam int CNT_W   = $clog2(BAUD_DR);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DR / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DR - 1);

  rx_state_t        state, next_state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic [1:0]       frame_par;
  logic             par_bad;
  logic             rxd_s, rxd_fall;
  logic             hit_half, hit_full;
  logic             latch_par, shift_en, par_sample, stop_sample;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .rxd_s    (rxd_s),
    .rxd_fall (rxd_fall)
  );

  assign hit_half = (baud_cnt == CNT_HALF);
  assign hit_full = (baud_cnt == CNT_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (rxd_fall) next_state = ST_START;
      // A line that is high again at mid start bit was only a glitch.
      ST_START:  if (hit_half) next_state = rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA:   if (hit_full && bit_cnt == 3'd7)
                   next_state = parity_enabled(frame_par) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (hit_full) next_state = ST_STOP;
      ST_STOP:   if (hit_full) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    rxd_busy    = (state != ST_IDLE);
    latch_par   = (state == ST_IDLE) && rxd_fall;
    shift_en    = (state == ST_DATA) && hit_full;
    par_sample  = (state == ST_PARITY) && hit_full;
    stop_sample = (state == ST_STOP) && hit_full;
  end

  // Datapath: baud counter, bit counter, shift register and the registered frame results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt   <= '0;
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'h00;
      frame_par  <= 2'b00;
      par_bad    <= 1'b0;
      rxd_data   <= 8'h00;
      rxd_done   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rxd_done <= 1'b0;

      case (state)
        ST_IDLE:  baud_cnt <= '0;
        ST_START: baud_cnt <= hit_half ? '0 : baud_cnt + 1'b1;
        default:  baud_cnt <= hit_full ? '0 : baud_cnt + 1'b1;
      endcase

      if (state != ST_DATA) begin
        bit_cnt <= 3'd0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (latch_par) begin
        frame_par <= parity;
        par_bad   <= 1'b0;
      end

      if (shift_en) begin
        shift_reg <= {rxd_s, shift_reg[7:1]};
      end

      // Even mode wants an even count of ones over data plus parity bit; odd mode inverts that.
      if (par_sample) begin
        par_bad <= (^shift_reg) ^ rxd_s ^ (frame_par == P_ODD);
      end

      if (stop_sample) begin
        rxd_data   <= shift_reg;
        parity_err <= parity_enabled(frame_par) & par_bad;
        frame_err  <= ~rxd_s;
        rxd_done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rxd.sv
// Directed self-checking bench for uart_rxd: bit-level line driver, strobe monitor, one task per scenario.
module tb_uart_rxd;

  localparam int BAUD_DR = 434;
  localparam int LAT_NP  = 4126;
  localparam int LAT_P   = 4560;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [1:0] parity = 2'b10;
  logic [7:0] rxd_data;
  logic       rxd_done;
  logic       parity_err;
  logic       frame_err;
  logic       rxd_busy;

  int n_cmp = 0;
  int n_bad = 0;

  int         cyc = 0;
  int         e_cycle = 0;
  int         done_cnt = 0;
  int         done_cycle = 0;
  logic [7:0] cap_data = 8'h00;
  logic       cap_pe = 1'b0;
  logic       cap_fe = 1'b0;

  logic [7:0] lb_data [3] = '{8'h00, 8'hFF, 8'h80};
  logic       lb_even [3] = '{1'b0, 1'b0, 1'b1};
  logic       lb_odd  [3] = '{1'b1, 1'b1, 1'b0};

  uart_rxd dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .parity     (parity),
    .rxd_data   (rxd_data),
    .rxd_done   (rxd_done),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rxd_busy   (rxd_busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rxd_done === 1'b1) begin
      done_cnt   = done_cnt + 1;
      done_cycle = cyc;
      cap_data   = rxd_data;
      cap_pe     = parity_err;
      cap_fe     = frame_err;
    end
  end

  task automatic send_frame(input logic [7:0] data, input logic use_par,
                            input logic par_bit, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    e_cycle = cyc;
    repeat (BAUD_DR) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (BAUD_DR) @(negedge clk);
    end
    if (use_par) begin
      rxd = par_bit;
      repeat (BAUD_DR) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BAUD_DR) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (rxd_data !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_data: got %h want 00", rxd_data); end
    n_cmp++; if (rxd_done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done: got %b want 0", rxd_done); end
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_perr: got %b want 0", parity_err); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ferr: got %b want 0", frame_err); end
    n_cmp++; if (rxd_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b want 0", rxd_busy); end
  endtask

  task automatic test_no_parity();
    int base, lat;
    parity = 2'b10;
    base = done_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    lat = done_cycle - e_cycle;
    n_cmp++; if (done_cnt !== base + 1) begin n_bad++; $display("[TB] FAIL np_strobes: got %0d want %0d", done_cnt - base, 1); end
    n_cmp++; if (lat < LAT_NP - 3 || lat > LAT_NP + 3) begin n_bad++; $display("[TB] FAIL np_latency: got %0d want %0d+-3", lat, LAT_NP); end
    n_cmp++; if (cap_data !== 8'hA5) begin n_bad++; $display("[TB] FAIL np_data: got %h want a5", cap_data); end
    n_cmp++; if (cap_pe !== 1'b0) begin n_bad++; $display("[TB] FAIL np_perr: got %b want 0", cap_pe); end
    n_cmp++; if (cap_fe !== 1'b0) begin n_bad++; $display("[TB] FAIL np_ferr: got %b want 0", cap_fe); end
    n_cmp++; if (rxd_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL np_busy: got %b want 0", rxd_busy); end
  endtask

  task automatic test_even_parity();
    int base, lat;
    parity = 2'b00;
    base = done_cnt;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    lat = done_cycle - e_cycle;
    n_cmp++; if (done_cnt !== base + 1) begin n_bad++; $display("[TB] FAIL ev_strobes: got %0d want 1", done_cnt - base); end
    n_cmp++; if (lat < LAT_P - 3 || lat > LAT_P + 3) begin n_bad++; $display("[TB] FAIL ev_latency: got %0d want %0d+-3", lat, LAT_P); end
    n_cmp++; if (cap_data !== 8'h3C) begin n_bad++; $display("[TB] FAIL ev_data: got %h want 3c", cap_data); end
    n_cmp++; if (cap_pe !== 1'b0) begin n_bad++; $display("[TB] FAIL ev_perr: got %b want 0", cap_pe); end
  endtask

  task automatic test_odd_parity_err();
    int base;
    parity = 2'b01;
    base = done_cnt;
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (cap_data !== 8'h01) begin n_bad++; $display("[TB] FAIL odd_data: got %h want 01", cap_data); end
    n_cmp++; if (cap_pe !== 1'b1) begin n_bad++; $display("[TB] FAIL odd_perr: got %b want 1", cap_pe); end
    repeat (300) @(negedge clk);
    n_cmp++; if (parity_err !== 1'b1) begin n_bad++; $display("[TB] FAIL odd_perr_hold: got %b want 1", parity_err); end
    send_frame(8'h01, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (done_cnt !== base + 2) begin n_bad++; $display("[TB] FAIL odd_strobes: got %0d want 2", done_cnt - base); end
    n_cmp++; if (cap_pe !== 1'b0) begin n_bad++; $display("[TB] FAIL odd_perr_clear: got %b want 0", cap_pe); end
  endtask

  task automatic test_frame_err();
    int base;
    parity = 2'b10;
    base = done_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (cap_fe !== 1'b1) begin n_bad++; $display("[TB] FAIL fe_flag: got %b want 1", cap_fe); end
    n_cmp++; if (cap_data !== 8'h55) begin n_bad++; $display("[TB] FAIL fe_data: got %h want 55", cap_data); end
    repeat (2000) @(negedge clk);
    n_cmp++; if (done_cnt !== base + 1) begin n_bad++; $display("[TB] FAIL fe_break_strobes: got %0d want 1", done_cnt - base); end
    n_cmp++; if (rxd_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL fe_break_busy: got %b want 0", rxd_busy); end
    rxd = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_glitch();
    int base, busy_cycles;
    base = done_cnt;
    busy_cycles = 0;
    @(negedge clk);
    rxd = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 99) rxd = 1'b1;
      if (rxd_busy === 1'b1) busy_cycles++;
    end
    n_cmp++; if (done_cnt !== base) begin n_bad++; $display("[TB] FAIL gl_strobes: got %0d want 0", done_cnt - base); end
    n_cmp++; if (busy_cycles < 214 || busy_cycles > 220) begin n_bad++; $display("[TB] FAIL gl_busy_len: got %0d want 217+-3", busy_cycles); end
    n_cmp++; if (rxd_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL gl_busy_end: got %b want 0", rxd_busy); end
    n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("[TB] FAIL gl_ferr_hold: got %b want 1", frame_err); end
    n_cmp++; if (rxd_data !== 8'h55) begin n_bad++; $display("[TB] FAIL gl_data_hold: got %h want 55", rxd_data); end
  endtask

  task automatic test_back_to_back();
    int base;
    logic [1:0] mode;
    for (int m = 0; m < 3; m++) begin
      mode = 2'(m);
      parity = mode;
      base = done_cnt;
      for (int k = 0; k < 3; k++) begin
        send_frame(lb_data[k], (m != 2), (m == 0) ? lb_even[k] : lb_odd[k], 1'b1);
        n_cmp++; if (cap_data !== lb_data[k]) begin n_bad++; $display("[TB] FAIL b2b_data m%0d f%0d: got %h want %h", m, k, cap_data, lb_data[k]); end
        n_cmp++; if (cap_pe !== 1'b0 || cap_fe !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_flags m%0d f%0d: got pe=%b fe=%b want 0/0", m, k, cap_pe, cap_fe); end
      end
      n_cmp++; if (done_cnt !== base + 3) begin n_bad++; $display("[TB] FAIL b2b_strobes m%0d: got %0d want 3", m, done_cnt - base); end
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    parity = 2'b10;
    @(negedge clk);
    rxd = 1'b0;
    repeat (BAUD_DR * 5) @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    base = done_cnt;
    rst = 1'b1;
    #1;
    n_cmp++; if (rxd_data !== 8'h00) begin n_bad++; $display("[TB] FAIL rst_mid_data: got %h want 00", rxd_data); end
    n_cmp++; if (rxd_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_busy: got %b want 0", rxd_busy); end
    n_cmp++; if (rxd_done !== 1'b0 || parity_err !== 1'b0 || frame_err !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_flags: got done=%b pe=%b fe=%b want 0/0/0", rxd_done, parity_err, frame_err); end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (1800) @(negedge clk);
    n_cmp++; if (done_cnt !== base) begin n_bad++; $display("[TB] FAIL rst_mid_strobes: got %0d want 0", done_cnt - base); end
    parity = 2'b00;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (done_cnt !== base + 1) begin n_bad++; $display("[TB] FAIL rst_clean_strobes: got %0d want 1", done_cnt - base); end
    n_cmp++; if (cap_data !== 8'h3C || cap_pe !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_clean_frame: got %h pe=%b want 3c pe=0", cap_data, cap_pe); end
  endtask

  initial begin
    $display("[TB] starting uart_rxd bench");
    test_reset();
    test_no_parity();
    test_even_parity();
    test_odd_parity_err();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
